// File: rtl/fire_controller_if.sv
// Signal bundle between the fire controller and its surroundings (keyboard, frame clock,
// projectile stage and HUD). The controller is the master of the launch request.
interface fire_controller_if;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic        missile_active;
    logic        shoot;
    logic        ready;
    logic [3:0]  ammo;
    logic [15:0] shots_fired;

    modport master (
        input  frame_clk, keycode, missile_active,
        output shoot, ready, ammo, shots_fired
    );

    modport slave (
        output frame_clk, keycode, missile_active,
        input  shoot, ready, ammo, shots_fired
    );
endinterface

// File: rtl/fire_controller.sv
// Turns fire-key presses into projectile launch requests, tracking each shot through
// launch, flight and cooldown while maintaining a regenerating ammo count and shot counter.
module fire_controller #(
    parameter logic [7:0] FIRE_KEY        = 8'h2C,
    parameter logic [3:0] MAX_AMMO        = 4'd5,
    parameter logic [7:0] RELOAD_FRAMES   = 8'd60,
    parameter logic [7:0] COOLDOWN_FRAMES = 8'd8,
    parameter logic [3:0] ARM_TIMEOUT     = 4'd4
) (
    input logic               Clk,
    input logic               Reset_n,
    fire_controller_if.master bus
);

    typedef enum logic [1:0] {StIdle, StArmed, StFlight, StCooldown} state_e;

    state_e      state_q, state_d;
    logic        f_d1_q, f_d1_d;
    logic        f_d2_q, f_d2_d;
    logic        fire_prev_q, fire_prev_d;
    logic [3:0]  arm_cnt_q, arm_cnt_d;
    logic [7:0]  cd_cnt_q, cd_cnt_d;
    logic [7:0]  rl_cnt_q, rl_cnt_d;
    logic [3:0]  ammo_q, ammo_d;
    logic [15:0] shots_q, shots_d;

    logic tick, fire_now, press, launch, reload;

    always_comb begin
        f_d1_d      = bus.frame_clk;
        f_d2_d      = f_d1_q;
        tick        = f_d1_q & ~f_d2_q;
        fire_now    = (bus.keycode == FIRE_KEY);
        press       = tick & fire_now & ~fire_prev_q;
        fire_prev_d = tick ? fire_now : fire_prev_q;

        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        cd_cnt_d  = cd_cnt_q;
        launch    = 1'b0;

        case (state_q)
            StIdle: begin
                // Presses that cannot be honoured right now are dropped, not queued.
                if (press && (ammo_q != 4'd0) && !bus.missile_active) begin
                    state_d   = StArmed;
                    arm_cnt_d = 4'd0;
                end
            end
            StArmed: begin
                if (bus.missile_active) begin
                    state_d = StFlight;
                    launch  = 1'b1;
                end else if (tick) begin
                    arm_cnt_d = arm_cnt_q + 4'd1;
                    if (arm_cnt_q == ARM_TIMEOUT - 4'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            StFlight: begin
                if (!bus.missile_active) begin
                    if (COOLDOWN_FRAMES == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        state_d  = StCooldown;
                        cd_cnt_d = COOLDOWN_FRAMES;
                    end
                end
            end
            StCooldown: begin
                if (tick) begin
                    cd_cnt_d = cd_cnt_q - 8'd1;
                    if (cd_cnt_q == 8'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Reload runs only while below capacity, independent of the shot sequence.
        rl_cnt_d = rl_cnt_q;
        reload   = 1'b0;
        if (ammo_q == MAX_AMMO) begin
            rl_cnt_d = 8'd0;
        end else if (tick) begin
            if (rl_cnt_q == RELOAD_FRAMES - 8'd1) begin
                rl_cnt_d = 8'd0;
                reload   = 1'b1;
            end else begin
                rl_cnt_d = rl_cnt_q + 8'd1;
            end
        end

        ammo_d = ammo_q;
        if (reload && !launch) begin
            ammo_d = ammo_q + 4'd1;
        end else if (launch && !reload) begin
            ammo_d = ammo_q - 4'd1;
        end

        shots_d = shots_q + {15'd0, launch};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            f_d1_q      <= 1'b0;
            f_d2_q      <= 1'b0;
            fire_prev_q <= 1'b1;
            arm_cnt_q   <= 4'd0;
            cd_cnt_q    <= 8'd0;
            rl_cnt_q    <= 8'd0;
            ammo_q      <= MAX_AMMO;
            shots_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            f_d1_q      <= f_d1_d;
            f_d2_q      <= f_d2_d;
            fire_prev_q <= fire_prev_d;
            arm_cnt_q   <= arm_cnt_d;
            cd_cnt_q    <= cd_cnt_d;
            rl_cnt_q    <= rl_cnt_d;
            ammo_q      <= ammo_d;
            shots_q     <= shots_d;
        end
    end

    assign bus.shoot       = (state_q == StArmed);
    assign bus.ready       = (state_q == StIdle) && (ammo_q != 4'd0);
    assign bus.ammo        = ammo_q;
    assign bus.shots_fired = shots_q;

endmodule
